// File: rtl/grant_mux.sv
// ---------------------------------------------------------------------------
// grant_mux
//
// Captures the payload of the requester selected by an upstream round-robin
// arbiter's registered grant vector and queues {source index, payload} in a
// small FIFO for a downstream consumer.
//
// Parameters
//   N      number of requesters (2..16)
//   DW     payload width per requester
//   DEPTH  output queue entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   grant       [N]      registered grant vector, one-hot or zero
//   req_data    [N*DW]   flattened payloads, requester i at [i*DW +: DW]
//   req_ack     [N]      one-cycle pulse to the requester that was captured
//   stall       [1]      asks upstream to hold all requests low
//   out_valid   [1]      queue head is valid
//   out_data    [DW]     queue head payload
//   out_src     [clog2N] queue head requester index
//   out_ready   [1]      downstream accepts the head
//   err_ovf     [1]      sticky: a grant was dropped because the queue was full
//   err_onehot  [1]      sticky: a multi-bit grant was discarded
//                        (only with GRANT_MUX_ONEHOT_CHK_EN, else tied 0)
//
// Configuration macro
//   GRANT_MUX_ONEHOT_CHK_EN  when defined, multi-bit grants are discarded and
//                            flagged on err_onehot; when undefined, the lowest
//                            set grant bit wins.
//
// Output handshake: the head entry transfers on every rising edge where
// out_valid && out_ready are both 1. While out_valid=1 and out_ready=0 the
// head (out_data/out_src) holds steady; out_valid never drops without a
// transfer except on reset.
// ---------------------------------------------------------------------------
module grant_mux #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         grant,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         req_ack,
  output logic                 stall,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready,
  output logic                 err_ovf,
  output logic                 err_onehot
);

  localparam int SW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_STALL = CW'(DEPTH - 1);

  // Queue storage: deliberately not reset; out_valid qualifies the head.
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [SW-1:0] r_mem_src  [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_ack;
  logic          r_err_ovf;

  logic          w_any;
  logic          w_ok;
  logic [SW-1:0] w_sel;
  logic [DW-1:0] w_sel_data;
  logic [N-1:0]  w_ack_vec;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  // Priority encoder: scanning from the top down means the lowest set bit is
  // the last assignment, so it wins when more than one bit is set.
  always_comb begin
    w_sel      = '0;
    w_sel_data = '0;
    w_ack_vec  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (grant[i]) begin
        w_sel      = SW'(i);
        w_sel_data = req_data[i*DW +: DW];
        w_ack_vec  = N'(1) << i;
      end
    end
  end

  assign w_any = |grant;

`ifdef GRANT_MUX_ONEHOT_CHK_EN
  logic w_multi;
  logic r_err_onehot;

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign w_multi = |(grant & (grant - N'(1)));
  assign w_ok    = w_any && !w_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_onehot <= 1'b0;
    end else if (w_multi) begin
      r_err_onehot <= 1'b1;
    end
  end

  assign err_onehot = r_err_onehot;
`else
  assign w_ok       = w_any;
  assign err_onehot = 1'b0;
`endif

  assign w_full = (r_count == C_FULL);
  assign w_pop  = out_valid && out_ready;
  // A full queue still accepts a grant when the head leaves in the same cycle.
  assign w_push = w_ok && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_sel_data;
      r_mem_src[r_wptr]  <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ack     <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_ack <= w_push ? w_ack_vec : '0;
      if (w_ok && w_full && !w_pop) r_err_ovf <= 1'b1;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem_data[r_rptr];
  assign out_src   = r_mem_src[r_rptr];
  // One slot is held back for the grant the arbiter has already registered.
  assign stall     = (r_count >= C_STALL);
  assign req_ack   = r_ack;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_grant_mux.sv
module tb_grant_mux;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int SW    = 2;
  localparam int W     = SW + DW;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    grant;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic            stall;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            err_ovf;
  logic            err_onehot;

  grant_mux #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .grant      (grant),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .err_ovf    (err_ovf),
    .err_onehot (err_onehot)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_ack;
  logic         m_ovf;
  logic         m_eoh;
  logic [N*DW-1:0] fixed_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ack = '0;
    m_ovf = 1'b0;
    m_eoh = 1'b0;
  endtask

  // Applies the queue rules to the inputs present at this rising edge.
  task automatic model_edge();
    bit ok;
    bit pop;
    bit push;
    bit full;
    int idx;
    ok  = (grant != '0);
`ifdef GRANT_MUX_ONEHOT_CHK_EN
    if ($countones(grant) > 1) begin
      ok    = 1'b0;
      m_eoh = 1'b1;
    end
`endif
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        idx = i;
        break;
      end
    end
    pop  = (exp_q.size() > 0) && out_ready;
    full = (exp_q.size() == DEPTH);
    push = ok && (!full || pop);
    if (ok && !push) m_ovf = 1'b1;
    m_ack = push ? (N'(1) << idx) : '0;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back({SW'(idx), req_data[idx*DW +: DW]});
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk({tag, " src"},  out_src,  exp_q[0][W-1:DW]);
      chk({tag, " data"}, out_data, exp_q[0][DW-1:0]);
    end
    chk({tag, " stall"},   stall,      exp_q.size() >= DEPTH - 1);
    chk({tag, " ack"},     req_ack,    m_ack);
    chk({tag, " ovf"},     err_ovf,    m_ovf);
    chk({tag, " onehot"},  err_onehot, m_eoh);
  endtask

  // ---------------- driver tasks ----------------
  // Entered at a falling edge: drive, take one rising edge, return at the next
  // falling edge where outputs are sampled.
  task automatic step(input logic [N-1:0] g, input logic r, input logic [N*DW-1:0] d);
    grant     = g;
    out_ready = r;
    req_data  = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    grant     = '0;
    out_ready = 1'b0;
    #2;
    rst_n     = 1'b1;
    model_clear();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic [N-1:0]  grant;
    logic          ready;
    logic          exp_valid;
    logic [SW-1:0] exp_src;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  exp_ack;
    logic          exp_stall;
    logic          exp_ovf;
    logic          exp_eoh;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic rst, logic [N-1:0] g, logic r, logic v, logic [SW-1:0] s,
                              logic [DW-1:0] d, logic [N-1:0] a, logic st, logic o, logic e);
    vec_t x;
    x.rst = rst; x.grant = g; x.ready = r; x.exp_valid = v; x.exp_src = s;
    x.exp_data = d; x.exp_ack = a; x.exp_stall = st; x.exp_ovf = o; x.exp_eoh = e;
    return x;
  endfunction

  initial begin
    rst_n     = 1'b0;
    grant     = '0;
    out_ready = 1'b0;
    req_data  = '0;
    model_clear();
    for (int i = 0; i < N; i++) fixed_data[i*DW +: DW] = 32'hCAFE0000 + i;

    // Reset state, sampled while rst_n is still low.
    @(negedge clk);
    chk("reset valid",  out_valid,  1'b0);
    chk("reset stall",  stall,      1'b0);
    chk("reset ack",    req_ack,    '0);
    chk("reset ovf",    err_ovf,    1'b0);
    chk("reset onehot", err_onehot, 1'b0);

    //                rst  grant    rdy val src   data          ack      stl ovf eoh
    vecs[0]  = mk(1'b1, 4'b0100, 1, 1, 2'd2, 32'hCAFE0002, 4'b0100, 1, 0, 0);
    vecs[1]  = mk(1'b0, 4'b0000, 1, 0, 2'd0, 32'h0,        4'b0000, 0, 0, 0);
    vecs[2]  = mk(1'b0, 4'b0001, 0, 1, 2'd0, 32'hCAFE0000, 4'b0001, 1, 0, 0);
    vecs[3]  = mk(1'b0, 4'b1000, 0, 1, 2'd0, 32'hCAFE0000, 4'b1000, 1, 0, 0);
    vecs[4]  = mk(1'b0, 4'b0010, 0, 1, 2'd0, 32'hCAFE0000, 4'b0000, 1, 1, 0);
    vecs[5]  = mk(1'b0, 4'b0000, 1, 1, 2'd3, 32'hCAFE0003, 4'b0000, 1, 1, 0);
    vecs[6]  = mk(1'b0, 4'b0000, 1, 0, 2'd0, 32'h0,        4'b0000, 0, 1, 0);
    vecs[7]  = mk(1'b1, 4'b0100, 0, 1, 2'd2, 32'hCAFE0002, 4'b0100, 1, 0, 0);
    vecs[8]  = mk(1'b0, 4'b1000, 0, 1, 2'd2, 32'hCAFE0002, 4'b1000, 1, 0, 0);
    vecs[9]  = mk(1'b0, 4'b0001, 1, 1, 2'd3, 32'hCAFE0003, 4'b0001, 1, 0, 0);
    vecs[10] = mk(1'b0, 4'b0000, 1, 1, 2'd0, 32'hCAFE0000, 4'b0000, 1, 0, 0);
    vecs[11] = mk(1'b0, 4'b0000, 1, 0, 2'd0, 32'h0,        4'b0000, 0, 0, 0);
`ifdef GRANT_MUX_ONEHOT_CHK_EN
    vecs[12] = mk(1'b1, 4'b0110, 0, 0, 2'd0, 32'h0,        4'b0000, 0, 0, 1);
    vecs[13] = mk(1'b0, 4'b0000, 1, 0, 2'd0, 32'h0,        4'b0000, 0, 0, 1);
`else
    vecs[12] = mk(1'b1, 4'b0110, 0, 1, 2'd1, 32'hCAFE0001, 4'b0010, 1, 0, 0);
    vecs[13] = mk(1'b0, 4'b0000, 1, 0, 2'd0, 32'h0,        4'b0000, 0, 0, 0);
`endif

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].grant, vecs[i].ready, fixed_data);
      chk($sformatf("row%0d valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("row%0d src", i),  out_src,  vecs[i].exp_src);
        chk($sformatf("row%0d data", i), out_data, vecs[i].exp_data);
      end
      chk($sformatf("row%0d ack", i),    req_ack,    vecs[i].exp_ack);
      chk($sformatf("row%0d stall", i),  stall,      vecs[i].exp_stall);
      chk($sformatf("row%0d ovf", i),    err_ovf,    vecs[i].exp_ovf);
      chk($sformatf("row%0d onehot", i), err_onehot, vecs[i].exp_eoh);
    end

    // Half-cycle reset with two entries queued and err_ovf already set.
    do_reset();
    step(4'b0001, 1'b0, fixed_data);
    step(4'b0010, 1'b0, fixed_data);
    step(4'b0100, 1'b0, fixed_data);
    chk("pre-rst valid", out_valid, 1'b1);
    chk("pre-rst ovf",   err_ovf,   1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst valid", out_valid, 1'b0);
    chk("mid-rst stall", stall,     1'b0);
    chk("mid-rst ovf",   err_ovf,   1'b0);
    chk("mid-rst ack",   req_ack,   '0);
    #2;
    grant     = 4'b1000;
    out_ready = 1'b0;
    req_data  = fixed_data;
    rst_n     = 1'b1;
    model_clear();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("post-rst valid", out_valid, 1'b1);
    chk("post-rst src",   out_src,   2'd3);
    chk("post-rst data",  out_data,  32'hCAFE0003);
    chk("post-rst ack",   req_ack,   4'b1000);
    check_model("post-rst");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0]    g;
      logic [N*DW-1:0] d;
      int              sel;
      if (c % 150 == 0) do_reset();
      sel = $urandom_range(0, 9);
      if (sel < 3)      g = '0;
      else if (sel < 9) g = N'(1) << $urandom_range(0, N - 1);
      else              g = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
      step(g, 1'($urandom_range(0, 1)), d);
      check_model($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grant_mux.md
GRANT_MUX -- requirements
Module: grant_mux

Interface
REQ-001 The block SHALL have parameter N, default 4: number of requesters, 2..16.
REQ-002 The block SHALL have parameter DW, default 32: payload width per requester.
REQ-003 The block SHALL have parameter DEPTH, default 2: output queue entries, a power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port grant, input, N: registered grant vector from the upstream round-robin arbiter, one-hot or zero.
REQ-007 The block SHALL have port req_data, input, N*DW: flattened payloads; requester i occupies bits [i*DW +: DW].
REQ-008 The block SHALL have port req_ack, output, N: one-cycle pulse to the requester whose payload was captured.
REQ-009 The block SHALL have port stall, output, 1: tells upstream to gate all req low.
REQ-010 The block SHALL have port out_valid, output, 1: the queue head is valid.
REQ-011 The block SHALL have port out_data, output, DW: the queue head payload.
REQ-012 The block SHALL have port out_src, output, clog2(N): the requester index of the queue head.
REQ-013 The block SHALL have port out_ready, input, 1: downstream accepts the head.
REQ-014 The block SHALL have port err_ovf, output, 1: sticky flag set when a grant is dropped because the queue is full.

Function
REQ-015 Capture: in a cycle with grant!=0 and the queue not full, or full with pop, the block SHALL push {index, req_data slice} of the granted requester.
REQ-016 req_ack SHALL be registered: it SHALL equal the captured grant bit one cycle after the capture, and zero otherwise.
REQ-017 Pop: out_valid&&out_ready SHALL remove the head, and the next entry SHALL appear on the following cycle.
REQ-018 out_data and out_src SHALL be driven directly from the head entry (no extra latency), and SHALL be stable while out_valid&&!out_ready.
REQ-019 A push into an empty queue SHALL give out_valid=1 on the cycle after grant (one-cycle latency).
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order, including when the queue is full.
REQ-021 stall SHALL be combinational from the registered count: asserted when count >= DEPTH-1, leaving one slot for the grant already in flight.
REQ-022 A grant arriving when full without pop SHALL be dropped: no push, no req_ack, and err_ovf set to 1 until reset.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 grant==0 SHALL cause no push and no req_ack.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously clear req_ack, out_valid, err_ovf, count and pointers, and SHALL drive stall=0.
REQ-026 Queue storage SHALL NOT be reset, and out_data and out_src SHALL be don't-care while out_valid=0.
REQ-027 Reset mid-transfer SHALL discard all queued entries, and a grant present in the reset-release cycle SHALL be captured normally.

Configuration
REQ-028 With macro GRANT_MUX_ONEHOT_CHK_EN defined, a grant with more than one bit set SHALL be discarded (no push, no ack) and sticky output err_onehot SHALL be set until reset.
REQ-029 Without GRANT_MUX_ONEHOT_CHK_EN, a multi-bit grant SHALL select the lowest-index set bit, and err_onehot SHALL be tied to 0; the port SHALL exist in both builds.

Verification
REQ-030 The bench SHALL check: grant=4'b0100 with slot 2 data 0xCAFE0002 and out_ready=1, giving out_valid=1, out_data=0xCAFE0002, out_src=2 next cycle, and req_ack=4'b0100 for one cycle.
REQ-031 The bench SHALL check: out_ready=0 with grants 0001 then 1000 on consecutive cycles, giving stall=1 after the first push, a second push that fills the queue, and then in-order outputs src 0 then 3 once out_ready=1.
REQ-032 The bench SHALL check: queue full, out_ready=0 and grant=0010, giving no req_ack, err_ovf=1 that remains 1 after the queue drains, and a later pop returning only the earlier entries.
REQ-033 The bench SHALL check: queue full with out_ready=1 and grant=0001 in the same cycle, giving count still DEPTH, no err_ovf, and ack[0] pulsed.
REQ-034 The bench SHALL check: grant=4'b0110 with the macro defined giving no push and err_onehot=1, and without the macro giving a push from src 1 with err_onehot=0.
REQ-035 The bench SHALL check: rst_n pulsed low for a half cycle with 2 entries queued, giving out_valid, stall and err_ovf at 0 immediately, and a grant on the first cycle after release captured with out_valid=1 one cycle later.
